// File: rtl/mole_scheduler_pkg.sv
// Shared game package: FSM state encoding, parameter defaults and a small helper.
package mole_scheduler_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPick,
    StUp,
    StGap,
    StOver
  } state_e;

  localparam int unsigned DefNumHoles = 8;
  localparam int unsigned DefUpBase   = 400;
  localparam int unsigned DefUpRw     = 8;
  localparam int unsigned DefGapTicks = 200;
  localparam int unsigned DefMaxMiss  = 5;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mole_scheduler_if.sv
// Game bus between the scheduler and its surroundings (buttons, PRNG, display).
interface mole_scheduler_if #(
  parameter int unsigned NUM_HOLES = mole_scheduler_pkg::DefNumHoles
);
  logic                 start;
  logic                 stop;
  logic                 tick;
  logic [31:0]          rand_in;
  logic [NUM_HOLES-1:0] hit;
  logic [NUM_HOLES-1:0] mole;
  logic [7:0]           score;
  logic [3:0]           misses;
  logic                 hit_ok;
  logic                 game_over;
  logic                 busy;

  modport master (
    output start, stop, tick, rand_in, hit,
    input  mole, score, misses, hit_ok, game_over, busy
  );

  modport slave (
    input  start, stop, tick, rand_in, hit,
    output mole, score, misses, hit_ok, game_over, busy
  );
endinterface

// File: rtl/mole_scheduler_tick_down_timer.sv
// Loadable down-counter stepped by a timebase strobe; stops at zero.
module tick_down_timer #(
  parameter int unsigned Width = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             last
);
  logic [Width-1:0] count_q;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - Width'(1);
    end
  end

  assign zero = (count_q == '0);
  // The next decrement will reach zero.
  assign last = (count_q == Width'(1));
endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole round scheduler: picks holes, times mole-up and gap phases, keeps score.
module mole_scheduler
  import mole_scheduler_pkg::*;
#(
  parameter int unsigned NUM_HOLES = DefNumHoles,
  parameter int unsigned UP_BASE   = DefUpBase,
  parameter int unsigned UP_RW     = DefUpRw,
  parameter int unsigned GAP_TICKS = DefGapTicks,
  parameter int unsigned MAX_MISS  = DefMaxMiss
) (
  input logic               clk,
  input logic               rst,
  mole_scheduler_if.slave   bus
);
  localparam int unsigned HOLE_W = $clog2(NUM_HOLES);
  localparam int unsigned UpMax  = UP_BASE + (2 ** UP_RW) - 1;
  localparam int unsigned TimerW = $clog2(max_u(UpMax, GAP_TICKS) + 1);

  state_e              state_q, state_d;
  logic [HOLE_W-1:0]   prev_q, prev_d;
  logic [7:0]          score_q, score_d;
  logic [3:0]          misses_q, misses_d;
  logic                hit_ok_q, hit_ok_d;
  logic [NUM_HOLES-1:0] mole_q, mole_d;
  logic                busy_q, busy_d;
  logic                game_over_q, game_over_d;

  logic [HOLE_W-1:0]   cand, pick_hole;
  logic [TimerW-1:0]   up_load_val;
  logic                up_load, gap_load;
  logic                up_zero, up_last, gap_zero, gap_last;
  logic                up_expire, gap_done, valid_hit;

  // Bits of the PRNG word that play no part in hole or time selection.
  logic unused_rand;
  assign unused_rand = ^{bus.rand_in[31:8+UP_RW], bus.rand_in[7:HOLE_W]};

  assign cand        = bus.rand_in[HOLE_W-1:0];
  // Never repeat the previous hole: step to the neighbour, wrapping naturally.
  assign pick_hole   = (cand == prev_q) ? cand + HOLE_W'(1) : cand;
  assign up_load_val = TimerW'(UP_BASE) + TimerW'(bus.rand_in[8 +: UP_RW]);

  // prev_q doubles as the current hole while in UP.
  assign valid_hit = bus.hit[prev_q];
  assign up_expire = bus.tick && (up_last || up_zero);
  assign gap_done  = bus.tick && (gap_last || gap_zero);

  tick_down_timer #(.Width(TimerW)) u_up_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (up_load),
    .load_val (up_load_val),
    .dec      (bus.tick && (state_q == StUp)),
    .zero     (up_zero),
    .last     (up_last)
  );

  tick_down_timer #(.Width(TimerW)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (TimerW'(GAP_TICKS)),
    .dec      (bus.tick && (state_q == StGap)),
    .zero     (gap_zero),
    .last     (gap_last)
  );

  // Next-state, counters and registered-output values; stop overrides everything.
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    score_d  = score_q;
    misses_d = misses_q;
    hit_ok_d = 1'b0;
    up_load  = 1'b0;
    gap_load = 1'b0;

    unique case (state_q)
      StIdle, StOver: begin
        if (bus.start) begin
          score_d  = '0;
          misses_d = '0;
          if (state_q == StIdle) prev_d = '0;
          state_d  = StPick;
        end
      end
      StPick: begin
        prev_d  = pick_hole;
        up_load = 1'b1;
        state_d = StUp;
      end
      StUp: begin
        // A hit beats an expiring tick in the same cycle.
        if (valid_hit) begin
          score_d  = (score_q == 8'hff) ? score_q : score_q + 8'd1;
          hit_ok_d = 1'b1;
          gap_load = 1'b1;
          state_d  = StGap;
        end else if (up_expire) begin
          misses_d = misses_q + 4'd1;
          if (misses_d == 4'(MAX_MISS)) begin
            state_d = StOver;
          end else begin
            gap_load = 1'b1;
            state_d  = StGap;
          end
        end
      end
      StGap: begin
        if (gap_done) state_d = StPick;
      end
      default: state_d = StIdle;
    endcase

    if (bus.stop && (state_q != StIdle)) begin
      state_d  = StIdle;
      prev_d   = prev_q;
      score_d  = score_q;
      misses_d = misses_q;
      hit_ok_d = 1'b0;
      up_load  = 1'b0;
      gap_load = 1'b0;
    end

    mole_d      = (state_d == StUp) ? ({{(NUM_HOLES-1){1'b0}}, 1'b1} << prev_d) : '0;
    busy_d      = (state_d == StPick) || (state_d == StUp) || (state_d == StGap);
    game_over_d = (state_d == StOver);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      prev_q      <= '0;
      score_q     <= '0;
      misses_q    <= '0;
      hit_ok_q    <= 1'b0;
      mole_q      <= '0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      hit_ok_q    <= hit_ok_d;
      mole_q      <= mole_d;
      busy_q      <= busy_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.mole      = mole_q;
  assign bus.score     = score_q;
  assign bus.misses    = misses_q;
  assign bus.hit_ok    = hit_ok_q;
  assign bus.busy      = busy_q;
  assign bus.game_over = game_over_q;
endmodule

// File: doc/mole_scheduler.md
MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 Parameter NUM_HOLES, default 8: number of holes; SHALL be a power of two, range 2..16; HOLE_W = log2(NUM_HOLES).
REQ-002 Parameter UP_BASE, default 400: minimum mole-up time, in ticks.
REQ-003 Parameter UP_RW, default 8: width of the random up-time extension; the extension range is 0..2^UP_RW-1 ticks.
REQ-004 Parameter GAP_TICKS, default 200: idle ticks between moles.
REQ-005 Parameter MAX_MISS, default 5: number of misses that ends the game.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 start  in  1  one-cycle pulse; begins a game.
REQ-009 stop  in  1  one-cycle pulse; aborts the game.
REQ-010 tick  in  1  one-cycle timebase strobe (1 ms nominal).
REQ-011 rand_in  in  32  free-running output of the PRNG.
REQ-012 hit  in  NUM_HOLES  one-cycle per-hole button pulses, already debounced.
REQ-013 mole  out  NUM_HOLES  one-hot active mole; all-zero when no mole is up.
REQ-014 score  out  8  count of successful hits.
REQ-015 misses  out  4  count of expired moles.
REQ-016 hit_ok  out  1  one-cycle pulse on each successful hit.
REQ-017 game_over  out  1  level; high in OVER.
REQ-018 busy  out  1  level; high in PICK, UP and GAP.

Function
REQ-019 The FSM SHALL have states IDLE, PICK, UP, GAP, OVER; all outputs SHALL be registered.
REQ-020 IDLE: on start, clear score, misses and prev_hole, then go to PICK; all other inputs ignored.
REQ-021 PICK lasts exactly one cycle; it samples rand_in once:
  - cand = rand_in[HOLE_W-1:0].
  - If cand equals prev_hole, hole = (cand+1) mod NUM_HOLES; otherwise hole = cand.
  - up_timer = UP_BASE + rand_in[8+UP_RW-1:8].
  - prev_hole = hole; next state UP.
REQ-022 mole SHALL assert the one-hot hole bit on the first UP cycle, i.e. one cycle after PICK, and SHALL deassert in the cycle the FSM leaves UP.
REQ-023 UP, timer: each tick decrements up_timer; ticks outside UP and GAP have no effect.
REQ-024 UP, expiry: a tick that brings up_timer to 0 counts a miss (misses+1).
  - If the new misses value equals MAX_MISS, go to OVER.
  - Otherwise go to GAP with gap_timer = GAP_TICKS.
REQ-025 UP, valid hit: hit[hole]=1 in UP causes, in the same edge:
  - score+1, saturating at 255;
  - hit_ok pulse;
  - go to GAP.
REQ-026 Bits of hit other than hit[hole], and any hit outside UP, SHALL be ignored.
REQ-027 Simultaneous valid hit and expiring tick in the same cycle: the hit wins; no miss is counted.
REQ-028 GAP: each tick decrements gap_timer; reaching 0 goes to PICK.
REQ-029 OVER: mole=0; score and misses held; start clears both counters and goes to PICK.
REQ-030 stop in any state except IDLE: go to IDLE in one cycle; mole=0; score and misses held.
REQ-031 stop takes priority over start, hit and tick in the same cycle.
REQ-032 start while busy SHALL be ignored.
REQ-033 Timer widths SHALL hold UP_BASE+2^UP_RW-1 and GAP_TICKS without overflow.

Reset
REQ-034 rst SHALL asynchronously force: state=IDLE, mole=0, score=0, misses=0, hit_ok=0, game_over=0, busy=0, timers=0, prev_hole=0.
REQ-035 rst asserted mid-game SHALL abandon the game; after rst deasserts, the block SHALL wait in IDLE for start.

Structure
REQ-036 The FSM state encoding and the defaults for NUM_HOLES, GAP_TICKS and MAX_MISS SHALL live in the shared game package.
REQ-037 The PRNG SHALL be instantiated outside this block; the block only samples rand_in.
REQ-038 One sub-module, tick_down_timer, SHALL be used twice (once for up_timer, once for gap_timer): load, decrement on tick, zero flag.

Verification
REQ-039 rst, start, rand_in=0x00000203 at PICK -> mole=8'b0000_1000 one cycle after PICK; up_timer=400+2=402.
REQ-040 Two consecutive PICKs with rand_in[2:0]=5 -> second mole is hole 6; with 7 then 7 -> hole 7, then hole 0 (wrap).
REQ-041 hit[3] in the same cycle as the expiring tick -> score+1, hit_ok=1, misses unchanged, GAP entered.
REQ-042 Five expiries with no hits -> game_over=1, misses=5, mole=0; then start -> score=0, misses=0, PICK.
REQ-043 stop during UP -> IDLE next cycle, mole=0, score held; rst during GAP -> all outputs 0 immediately.
REQ-044 256 valid hits -> score saturates at 255; hit[2] while mole is on hole 3 -> no change.
